// File: rtl/trace_pkg.sv
// Shared types and helpers for the retire-trace path.
package trace_pkg;

    localparam int unsigned DefXlen = 32;
    localparam int unsigned DefSeqW = 32;
    localparam int unsigned RegW    = 5;
    localparam int unsigned PopW    = 32;

    typedef struct packed {
        logic [DefSeqW-1:0] seq;
        logic [DefXlen-1:0] pc;
        logic [DefXlen-1:0] instr;
        logic [RegW-1:0]    rd;
        logic [DefXlen-1:0] rd_data;
        logic               mem_wrt;
        logic [DefXlen-1:0] mem_addr;
        logic [DefXlen-1:0] mem_data;
    } trace_rec_t;

    function automatic int unsigned popcount(input logic [PopW-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < PopW; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/trace_lane_compact.sv
// Per-lane compaction offsets: exclusive prefix count of valid lanes, plus total count k.
module trace_lane_compact
    import trace_pkg::*;
#(
    parameter int unsigned NumLanes = 2,
    parameter int unsigned OffW     = $clog2(NumLanes + 1)
) (
    input  logic [NumLanes-1:0]           valid_i,
    output logic [NumLanes-1:0][OffW-1:0] offset_o,
    output logic [OffW-1:0]               k_o
);

    always_comb begin
        offset_o = '0;
        k_o      = OffW'(popcount(PopW'(valid_i)));
        for (int unsigned i = 1; i < NumLanes; i++) begin
            offset_o[i] = offset_o[i-1] + OffW'(valid_i[i-1]);
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: compacts valid commit lanes into a circular FIFO, drains one record per cycle.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned NumLanes = 2,
    parameter int unsigned XLEN     = DefXlen,
    parameter int unsigned Depth    = 16,
    parameter int unsigned CntW     = 16,
    parameter int unsigned SeqW     = DefSeqW,
    parameter int unsigned LvlW     = $clog2(Depth) + 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush_i,
    input  logic [NumLanes-1:0]           commit_valid_i,
    input  logic [NumLanes-1:0][XLEN-1:0] commit_pc_i,
    input  logic [NumLanes-1:0][XLEN-1:0] commit_instr_i,
    input  logic [NumLanes-1:0][RegW-1:0] commit_rd_i,
    input  logic [NumLanes-1:0][XLEN-1:0] commit_rd_data_i,
    input  logic [NumLanes-1:0]           commit_mem_wrt_i,
    input  logic [NumLanes-1:0][XLEN-1:0] commit_mem_addr_i,
    input  logic [NumLanes-1:0][XLEN-1:0] commit_mem_data_i,
    output logic                          commit_ready_o,
    output logic                          trace_valid_o,
    input  logic                          trace_ready_i,
    output trace_rec_t                    trace_rec_o,
    output logic [LvlW-1:0]               level_o,
    output logic [CntW-1:0]               drop_cnt_o
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned PtrW = IdxW + 1;
    localparam int unsigned OffW = $clog2(NumLanes + 1);

    if ((Depth & (Depth - 1)) != 0) begin : g_chk_pow2
        $error("Depth must be a power of two");
    end
    if (Depth < 2 * NumLanes) begin : g_chk_depth
        $error("Depth must be at least 2*NumLanes");
    end
    if (NumLanes < 1) begin : g_chk_lanes
        $error("NumLanes must be at least 1");
    end
    if (XLEN != DefXlen || SeqW != DefSeqW) begin : g_chk_rec
        $error("XLEN/SeqW must match the trace_rec_t layout");
    end
    if (LvlW != PtrW) begin : g_chk_lvl
        $error("LvlW must be $clog2(Depth)+1");
    end

    trace_rec_t mem_q [Depth];
    trace_rec_t mem_d [Depth];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] level_q, level_d;
    logic [SeqW-1:0] seq_q, seq_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;

    logic [NumLanes-1:0][OffW-1:0] lane_off;
    logic [OffW-1:0]               lane_k;
    logic                          push;
    logic                          pop;
    logic [CntW:0]                 drop_sum;
    logic [IdxW-1:0]               slot;
    trace_rec_t                    rec;

    trace_lane_compact #(
        .NumLanes (NumLanes),
        .OffW     (OffW)
    ) u_compact (
        .valid_i  (commit_valid_i),
        .offset_o (lane_off),
        .k_o      (lane_k)
    );

    // Next-state: compacted writes, pointer/level update, sequence and drop accounting.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;
        rec      = '0;
        slot     = '0;
        push     = ready_q && !flush_i;
        pop      = valid_q && trace_ready_i && !flush_i;
        seq_d    = seq_q + SeqW'(lane_k);
        drop_sum = {1'b0, drop_q} + (CntW + 1)'(lane_k);

        if (!push) begin
            drop_d = drop_sum[CntW] ? '1 : drop_sum[CntW-1:0];
        end

        if (push) begin
            for (int unsigned i = 0; i < NumLanes; i++) begin
                if (commit_valid_i[i]) begin
                    rec.seq      = seq_q + SeqW'(lane_off[i]);
                    rec.pc       = commit_pc_i[i];
                    rec.instr    = commit_instr_i[i];
                    rec.rd       = commit_rd_i[i];
                    rec.rd_data  = (commit_rd_i[i] == '0) ? '0 : commit_rd_data_i[i];
                    rec.mem_wrt  = commit_mem_wrt_i[i];
                    rec.mem_addr = commit_mem_wrt_i[i] ? commit_mem_addr_i[i] : '0;
                    rec.mem_data = commit_mem_wrt_i[i] ? commit_mem_data_i[i] : '0;
                    slot         = IdxW'(wr_ptr_q + PtrW'(lane_off[i]));
                    mem_d[slot]  = rec;
                end
            end
        end

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(lane_k);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            level_d = level_q + (push ? PtrW'(lane_k) : '0) - PtrW'(pop);
        end

        ready_d = (level_d <= PtrW'(Depth - NumLanes));
        valid_d = (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    // Storage needs no reset; validity is carried by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign commit_ready_o = ready_q;
    assign trace_valid_o  = valid_q;
    assign level_o        = level_q;
    assign drop_cnt_o     = drop_q;
    assign trace_rec_o    = valid_q ? mem_q[rd_ptr_q[IdxW-1:0]] : '0;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized scoreboard bench for commit_trace_buffer against a queue-based reference model.
module tb_commit_trace_buffer;
    import trace_pkg::*;

    localparam int unsigned NumLanes = 2;
    localparam int unsigned Depth    = 16;
    localparam int unsigned CntW     = 16;
    localparam int unsigned LvlW     = 5;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    flush_i;
    logic [NumLanes-1:0]     commit_valid_i;
    logic [NumLanes-1:0][31:0] commit_pc_i;
    logic [NumLanes-1:0][31:0] commit_instr_i;
    logic [NumLanes-1:0][4:0]  commit_rd_i;
    logic [NumLanes-1:0][31:0] commit_rd_data_i;
    logic [NumLanes-1:0]     commit_mem_wrt_i;
    logic [NumLanes-1:0][31:0] commit_mem_addr_i;
    logic [NumLanes-1:0][31:0] commit_mem_data_i;
    logic                    commit_ready_o;
    logic                    trace_valid_o;
    logic                    trace_ready_i;
    trace_rec_t              trace_rec_o;
    logic [LvlW-1:0]         level_o;
    logic [CntW-1:0]         drop_cnt_o;

    commit_trace_buffer #(
        .NumLanes (NumLanes),
        .Depth    (Depth),
        .CntW     (CntW)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .flush_i           (flush_i),
        .commit_valid_i    (commit_valid_i),
        .commit_pc_i       (commit_pc_i),
        .commit_instr_i    (commit_instr_i),
        .commit_rd_i       (commit_rd_i),
        .commit_rd_data_i  (commit_rd_data_i),
        .commit_mem_wrt_i  (commit_mem_wrt_i),
        .commit_mem_addr_i (commit_mem_addr_i),
        .commit_mem_data_i (commit_mem_data_i),
        .commit_ready_o    (commit_ready_o),
        .trace_valid_o     (trace_valid_o),
        .trace_ready_i     (trace_ready_i),
        .trace_rec_o       (trace_rec_o),
        .level_o           (level_o),
        .drop_cnt_o        (drop_cnt_o)
    );

    always #5 clk = ~clk;

    trace_rec_t  sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] m_seq;
    int unsigned m_drop;
    logic [31:0] pc_next;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare head record whenever the DUT presents one.
    always @(negedge clk) begin
        if (rstn === 1'b1 && trace_valid_o === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_record: got %h expected none at %0t", trace_rec_o, $time);
            end else begin
                if (trace_rec_o !== sb[0]) begin
                    n_err++;
                    $display("FAIL record: got %h expected %h at %0t", trace_rec_o, sb[0], $time);
                end
                if (trace_ready_i === 1'b1 && flush_i !== 1'b1) void'(sb.pop_front());
            end
        end
        if (rstn === 1'b1 && flush_i === 1'b1) sb.delete();
    end

    task automatic do_reset(input int cycles);
        rstn           = 1'b0;
        flush_i        = 1'b0;
        commit_valid_i = '0;
        trace_ready_i  = 1'b0;
        sb.delete();
        m_seq   = '0;
        m_drop  = 0;
        pc_next = 32'h8000_0000;
        repeat (cycles) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // One cycle: check outputs against the model, then apply new inputs and predict their effect.
    task automatic step(input logic [1:0] v, input logic rdy, input logic fl, input logic zap);
        int unsigned lvl;
        logic        exp_ready;
        int unsigned nlow;
        trace_rec_t  r;
        lvl       = sb.size();
        exp_ready = (Depth - lvl >= NumLanes);
        chk("level", 64'(level_o), 64'(lvl));
        chk("commit_ready", 64'(commit_ready_o), 64'(exp_ready));
        chk("trace_valid", 64'(trace_valid_o), 64'(lvl != 0));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
        if (lvl == 0) chk("idle_rec_nonzero", 64'(trace_rec_o != '0), 64'(0));

        commit_valid_i = v;
        trace_ready_i  = rdy;
        flush_i        = fl;
        nlow           = 0;
        for (int i = 0; i < NumLanes; i++) begin
            commit_pc_i[i]       = v[i] ? pc_next : $urandom;
            commit_instr_i[i]    = $urandom;
            commit_rd_i[i]       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            commit_rd_data_i[i]  = $urandom;
            commit_mem_wrt_i[i]  = 1'($urandom);
            commit_mem_addr_i[i] = $urandom;
            commit_mem_data_i[i] = $urandom;
            if (zap) begin
                commit_rd_i[i]      = 5'd0;
                commit_rd_data_i[i] = 32'hDEAD_BEEF;
                commit_mem_wrt_i[i] = 1'b0;
            end
            if (v[i]) begin
                r.seq      = m_seq + 32'(nlow);
                r.pc       = commit_pc_i[i];
                r.instr    = commit_instr_i[i];
                r.rd       = commit_rd_i[i];
                r.rd_data  = (commit_rd_i[i] == 5'd0) ? 32'd0 : commit_rd_data_i[i];
                r.mem_wrt  = commit_mem_wrt_i[i];
                r.mem_addr = commit_mem_wrt_i[i] ? commit_mem_addr_i[i] : 32'd0;
                r.mem_data = commit_mem_wrt_i[i] ? commit_mem_data_i[i] : 32'd0;
                if (exp_ready && !fl) sb.push_back(r);
                nlow++;
                pc_next += 32'd4;
            end
        end
        m_seq += 32'(nlow);
        if (!exp_ready || fl) begin
            m_drop = (m_drop + nlow > 65535) ? 65535 : m_drop + nlow;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        flush_i           = 1'b0;
        commit_valid_i    = '0;
        commit_pc_i       = '0;
        commit_instr_i    = '0;
        commit_rd_i       = '0;
        commit_rd_data_i  = '0;
        commit_mem_wrt_i  = '0;
        commit_mem_addr_i = '0;
        commit_mem_data_i = '0;
        trace_ready_i     = 1'b0;

        // Reset state
        do_reset(2);
        chk("reset_level", 64'(level_o), 64'(0));
        chk("reset_ready", 64'(commit_ready_o), 64'(1));
        chk("reset_valid", 64'(trace_valid_o), 64'(0));
        chk("reset_drop", 64'(drop_cnt_o), 64'(0));

        // Dual retire, then a hole with sanitising
        step(2'b11, 1'b1, 1'b0, 1'b0);
        repeat (3) step(2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b0, 1'b1);
        repeat (2) step(2'b00, 1'b1, 1'b0, 1'b0);

        // Backpressure to full, one dropped pair, drain, then seq 18
        do_reset(2);
        repeat (9) step(2'b11, 1'b0, 1'b0, 1'b0);
        chk("bp_level_full", 64'(level_o), 64'(16));
        chk("bp_drop", 64'(drop_cnt_o), 64'(2));
        chk("bp_ready_low", 64'(commit_ready_o), 64'(0));
        repeat (17) step(2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (2) step(2'b00, 1'b1, 1'b0, 1'b0);

        // Push and pop together at level 13
        do_reset(1);
        repeat (6) step(2'b11, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b0, 1'b0);
        chk("pp_level", 64'(level_o), 64'(14));
        repeat (16) step(2'b00, 1'b1, 1'b0, 1'b0);

        // Flush at level 5, then reset mid-stream
        do_reset(1);
        repeat (2) step(2'b11, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b1, 1'b0);
        chk("flush_level", 64'(level_o), 64'(0));
        chk("flush_drop", 64'(drop_cnt_o), 64'(1));
        step(2'b11, 1'b0, 1'b0, 1'b0);
        do_reset(1);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (2) step(2'b00, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with bursts of backpressure, flushes and resets
        for (int n = 0; n < 3000; n++) begin
            logic rdy;
            logic fl;
            rdy = ((n / 50) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 599) == 0) do_reset(1);
            step(2'($urandom), rdy, fl, $urandom_range(0, 9) == 0);
        end

        // Bounded final drain
        for (int n = 0; n < 40 && sb.size() != 0; n++) begin
            step(2'b00, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));
        step(2'b00, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
